// File: rtl/menu_pkg.sv
// Shared types and geometry for the battle-menu cursor.
package menu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SLOT_FIGHT = 2'd0,
        SLOT_ACT   = 2'd1,
        SLOT_ITEM  = 2'd2,
        SLOT_MERCY = 2'd3
    } slot_e;

    localparam int          N_ITEMS = 4;
    localparam logic [15:0] X_BASE  = 16'd65;
    localparam logic [15:0] X_PITCH = 16'd140;

    // Centre x of a slot, 16-bit unsigned.
    function automatic logic [15:0] target_x(input logic [1:0] idx);
        return X_BASE + 16'(idx) * X_PITCH;
    endfunction

endpackage

// File: rtl/menu_cursor_ctrl_btn_repeat.sv
// Press-edge detection plus hold-to-repeat for one direction button.
module btn_repeat #(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_tick,
    input  logic i_btn,
    input  logic i_active,
    output logic o_step
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             btn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic             rep_q, rep_d;
    logic             press, rep_fire;

    // Edge register, repeat counter and repeat-phase flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btn_q <= 1'b0;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            btn_q <= i_btn;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

    // Count frame ticks while held; first fire after the delay, then at the rate.
    always_comb begin
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        rep_fire = 1'b0;
        cnt_nxt  = cnt_q + 1'b1;
        press    = i_btn & ~btn_q;
        if (!(i_btn && i_active)) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (i_frame_tick) begin
            if (!rep_q && cnt_nxt == CNT_W'(REPEAT_DELAY)) begin
                rep_fire = 1'b1;
                cnt_d    = '0;
                rep_d    = 1'b1;
            end else if (rep_q && cnt_nxt == CNT_W'(REPEAT_RATE)) begin
                rep_fire = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_nxt;
            end
        end
        o_step = i_active & (press | rep_fire);
    end

endmodule

// File: rtl/menu_cursor_ctrl.sv
// Battle-menu cursor: slot selection, slide animation and confirm strobe.
module menu_cursor_ctrl
    import menu_pkg::*;
#(
    parameter int SLIDE_STEP   = 20,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_enable,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    input  logic        i_btn_confirm,
    input  logic        i_resume,
    output logic [1:0]  o_cursor_position,
    output logic [15:0] o_cx,
    output logic        o_moving,
    output logic        o_select_valid,
    output logic [1:0]  o_selected,
    output logic [1:0]  o_state
);

    state_e      state_q, state_d;
    logic [1:0]  index_q, index_d;
    logic [15:0] cx_q, cx_d, tgt_x;
    logic        conf_q;
    logic        valid_q, valid_d;
    logic [1:0]  selected_q, selected_d;

    logic in_select, rep_active, conf_edge, accept_conf;
    logic left_step, right_step;

    // Direction buttons; both held suppresses moves and clears the repeat counters.
    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_tick (i_frame_tick),
        .i_btn        (i_btn_left),
        .i_active     (rep_active),
        .o_step       (left_step)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_tick (i_frame_tick),
        .i_btn        (i_btn_right),
        .i_active     (rep_active),
        .o_step       (right_step)
    );

    // Menu state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state; dropping enable returns to IDLE ahead of everything else.
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_SELECT;
                ST_SELECT: if (conf_edge) state_d = ST_LOCKED;
                ST_LOCKED: if (i_resume)  state_d = ST_SELECT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State-derived controls: presses only count while selecting with the menu enabled.
    always_comb begin
        o_state     = state_q;
        conf_edge   = i_btn_confirm & ~conf_q;
        in_select   = (state_q == ST_SELECT) & i_enable;
        rep_active  = in_select & ~(i_btn_left & i_btn_right);
        accept_conf = in_select & conf_edge;
    end

    // Index, slide position, confirm edge register and selection outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            index_q    <= SLOT_FIGHT;
            cx_q       <= X_BASE;
            conf_q     <= 1'b0;
            valid_q    <= 1'b0;
            selected_q <= SLOT_FIGHT;
        end else begin
            index_q    <= index_d;
            cx_q       <= cx_d;
            conf_q     <= i_btn_confirm;
            valid_q    <= valid_d;
            selected_q <= selected_d;
        end
    end

    // Confirm beats a same-cycle move; o_cx walks toward the target on frame ticks.
    always_comb begin
        tgt_x      = target_x(index_q);
        index_d    = index_q;
        cx_d       = cx_q;
        valid_d    = accept_conf;
        selected_d = accept_conf ? index_q : selected_q;
        if (!accept_conf) begin
            if (left_step)       index_d = index_q - 2'd1;
            else if (right_step) index_d = index_q + 2'd1;
        end
        if (i_frame_tick && cx_q != tgt_x) begin
            if (cx_q < tgt_x) cx_d = cx_q + 16'(SLIDE_STEP);
            else              cx_d = cx_q - 16'(SLIDE_STEP);
        end
    end

    // Output drive from registers.
    always_comb begin
        o_cursor_position = index_q;
        o_cx              = cx_q;
        o_moving          = (cx_q != tgt_x);
        o_select_valid    = valid_q;
        o_selected        = selected_q;
    end

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Directed and randomised checks of menu_cursor_ctrl against a behavioural model.
module tb_menu_cursor_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, en = 1'b0, bl = 1'b0, br = 1'b0, bc = 1'b0, resume = 1'b0;
    logic [1:0]  pos, selected, state;
    logic [15:0] cx;
    logic        moving, valid;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_state, m_idx, m_cx, m_sel, m_lt, m_rt;
    bit m_valid, m_pl, m_pr, m_pc;

    always #5 clk = ~clk;

    menu_cursor_ctrl dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_frame_tick      (tick),
        .i_enable          (en),
        .i_btn_left        (bl),
        .i_btn_right       (br),
        .i_btn_confirm     (bc),
        .i_resume          (resume),
        .o_cursor_position (pos),
        .o_cx              (cx),
        .o_moving          (moving),
        .o_select_valid    (valid),
        .o_selected        (selected),
        .o_state           (state)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit rep_hit(input int n);
        return (n == 20) || (n > 20 && ((n - 20) % 8) == 0);
    endfunction

    // One clock of the model, from the spec's rules in plain integers.
    task automatic model_step();
        bit in_sel, le, re, ce, lstep, rstep;
        int tgt;
        if (!rst_n) begin
            m_state = 0; m_idx = 0; m_cx = 65; m_valid = 0; m_sel = 0;
            m_lt = 0; m_rt = 0; m_pl = 0; m_pr = 0; m_pc = 0;
        end else begin
            in_sel = (m_state == 1) && en;
            le = bl && !m_pl;
            re = br && !m_pr;
            ce = bc && !m_pc;
            lstep = 0;
            rstep = 0;
            if (in_sel && bl && !br) begin
                if (tick) m_lt++;
                lstep = le || (tick && rep_hit(m_lt));
            end else m_lt = 0;
            if (in_sel && br && !bl) begin
                if (tick) m_rt++;
                rstep = re || (tick && rep_hit(m_rt));
            end else m_rt = 0;
            tgt = 65 + 140 * m_idx;
            if (tick && m_cx != tgt) m_cx += (tgt > m_cx) ? 20 : -20;
            m_valid = in_sel && ce;
            if (m_valid)    m_sel = m_idx;
            else if (lstep) m_idx = (m_idx + 3) % 4;
            else if (rstep) m_idx = (m_idx + 1) % 4;
            if (!en)                            m_state = 0;
            else if (m_state == 0)              m_state = 1;
            else if (m_state == 1 && ce)        m_state = 2;
            else if (m_state == 2 && resume)    m_state = 1;
            m_pl = bl; m_pr = br; m_pc = bc;
        end
    endtask

    task automatic check_all();
        chk("position", int'(pos), m_idx);
        chk("cx", int'(cx), m_cx);
        chk("moving", int'(moving), int'(m_cx != 65 + 140 * m_idx));
        chk("select_valid", int'(valid), int'(m_valid));
        chk("selected", int'(selected), m_sel);
        chk("state", int'(state), m_state);
    endtask

    task automatic cyc(input bit t, input bit l, input bit r, input bit c,
                       input bit rs, input bit e, input bit rn);
        @(negedge clk);
        tick = t; bl = l; br = r; bc = c; resume = rs; en = e; rst_n = rn;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // n frame ticks, each followed by one quiet cycle, holding the given levels
    task automatic ticks(input int n, input bit l, input bit r, input bit e);
        for (int i = 0; i < n; i++) begin
            cyc(1, l, r, 0, 0, e, 1);
            cyc(0, l, r, 0, 0, e, 1);
        end
    endtask

    initial begin
        int n;
        // reset
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset_cx", int'(cx), 65);
        chk("reset_state", int'(state), 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("enter_select", int'(state), 1);

        // right press -> slot 1, slide 65 -> 205 in 7 ticks
        cyc(0, 0, 1, 0, 0, 1, 1);
        chk("right_press_pos", int'(pos), 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (moving) n++;
            cyc(1, 0, 0, 0, 0, 1, 1);
            cyc(0, 0, 0, 0, 0, 1, 1);
        end
        chk("slide1_moving_ticks", n, 7);
        chk("slide1_cx", int'(cx), 205);

        // back to 0, then wrap left to 3 and slide 21 ticks
        cyc(0, 1, 0, 0, 0, 1, 1);
        ticks(7, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1, 1);
        chk("wrap_left_pos", int'(pos), 3);
        ticks(20, 0, 0, 1);
        chk("wrap_left_cx20", int'(cx), 465);
        ticks(1, 0, 0, 1);
        chk("wrap_left_cx21", int'(cx), 485);

        // wrap right to 0, settle, then hold right for 36 ticks
        cyc(0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("wrap_right_pos", int'(pos), 0);
        ticks(21, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1, 1);
        ticks(28, 0, 1, 1);
        chk("hold28_pos", int'(pos), 3);
        ticks(8, 0, 1, 1);
        chk("hold36_pos", int'(pos), 0);
        cyc(0, 0, 0, 0, 0, 1, 1);

        // to slot 2, then confirm and right in the same cycle
        cyc(0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 1, 0, 1, 1);
        chk("confirm_valid", int'(valid), 1);
        chk("confirm_selected", int'(selected), 2);
        chk("confirm_pos", int'(pos), 2);
        chk("confirm_state", int'(state), 2);
        cyc(0, 0, 0, 1, 0, 1, 1);
        chk("confirm_one_shot", int'(valid), 0);
        cyc(0, 1, 0, 1, 0, 1, 1);
        chk("locked_ignores_left", int'(pos), 2);
        // confirm still held across resume: no re-fire
        cyc(0, 0, 0, 1, 1, 1, 1);
        chk("resume_state", int'(state), 1);
        cyc(0, 0, 0, 1, 0, 1, 1);
        chk("held_confirm_no_fire", int'(valid), 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 1, 1);
        chk("relock_state", int'(state), 2);

        // enable dropped in LOCKED, resume in IDLE ignored, index kept
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("drop_enable_state", int'(state), 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("idle_resume_ignored", int'(state), 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("reenter_state", int'(state), 1);
        chk("reenter_pos", int'(pos), 2);

        // reset mid-slide at cx=285
        ticks(10, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1, 1);
        ticks(3, 0, 0, 1);
        chk("midslide_cx", int'(cx), 285);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("midslide_reset_cx", int'(cx), 65);
        chk("midslide_reset_pos", int'(pos), 0);
        chk("midslide_reset_state", int'(state), 0);

        // randomised run against the model
        begin
            bit l, r, c;
            l = 0; r = 0; c = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 29) == 0) l = !l;
                if ($urandom_range(0, 29) == 0) r = !r;
                if ($urandom_range(0, 9)  == 0) c = !c;
                cyc($urandom_range(0, 2) == 0, l, r, c,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 59) != 0,
                    $urandom_range(0, 499) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
